// File: rtl/garbage_receiver_pkg.sv
// Shared sizing, queue entry layout and FSM encoding for the garbage receiver.
package DisplayPkg;

   localparam int GARBAGE_DEPTH  = 8;
   localparam int MAX_PENDING    = 20;
   localparam int MAX_INSERT     = 8;
   localparam int PLAYFIELD_COLS = 10;

   typedef struct packed {
      logic [3:0] count;
      logic [3:0] hole;
   } garbage_entry_t;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_CANCEL = 2'd1,
      ST_INSERT = 2'd2
   } gr_state_t;

   // Fold a raw random byte onto a playfield column index.
   function automatic logic [3:0] hole_from_rand(input logic [7:0] r);
      return 4'(r % 8'(PLAYFIELD_COLS));
   endfunction

endpackage

// File: rtl/garbage_receiver_lfsr.sv
// 8-bit maximal-length Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that steps only when enabled.
module garbage_lfsr (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   output logic [7:0] value
);

   logic feedback;

   assign feedback = value[7] ^ value[5] ^ value[4] ^ value[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= 8'hA5;
      end else if (en) begin
         value <= {value[6:0], feedback};
      end
   end

endmodule

// File: rtl/garbage_receiver.sv
// Queues incoming garbage packets, cancels them against local attacks and feeds rows to the playfield.
module garbage_receiver #(
   parameter int GARBAGE_DEPTH = DisplayPkg::GARBAGE_DEPTH,
   parameter int MAX_PENDING   = DisplayPkg::MAX_PENDING,
   parameter int MAX_INSERT    = DisplayPkg::MAX_INSERT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       game_start,
   input  logic       gb_valid,
   input  logic [3:0] gb_lines,
   output logic       gb_ready,
   input  logic       sent_valid,
   input  logic [4:0] sent_lines,
   output logic       sent_ready,
   output logic       cancel_valid,
   output logic [4:0] cancel_remainder,
   input  logic       lock_pulse,
   input  logic       lock_cleared,
   output logic       ins_valid,
   output logic [3:0] ins_hole,
   input  logic       ins_ready,
   output logic [4:0] pending_total,
   output logic       busy
);
   import DisplayPkg::*;

   localparam int PTR_W = (GARBAGE_DEPTH > 1) ? $clog2(GARBAGE_DEPTH) : 1;
   localparam int CNT_W = $clog2(GARBAGE_DEPTH + 1);
   localparam int INS_W = $clog2(MAX_INSERT + 1);

   function automatic logic [4:0] min5(input logic [4:0] a, input logic [4:0] b);
      return (a < b) ? a : b;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(GARBAGE_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   garbage_entry_t   fifo_mem [GARBAGE_DEPTH];
   garbage_entry_t   head;
   logic [PTR_W-1:0] rd_ptr, wr_ptr;
   logic [CNT_W-1:0] fifo_cnt;
   gr_state_t        state;
   logic [4:0]       rem;
   logic [INS_W-1:0] ins_cnt;
   logic             lock_pend, lock_pend_cleared;
   logic [7:0]       rand_val;

   logic       clr, empty, full, push, pop;
   logic       cancel_done, cancel_step, ins_fire, ins_last;
   logic       lock_now, lock_now_cleared;
   logic [4:0] room, store_cnt, dec_amt;
   logic [3:0] head_left;

   assign clr   = rst | game_start;
   assign head  = fifo_mem[rd_ptr];
   assign empty = (fifo_cnt == '0);
   assign full  = (fifo_cnt == CNT_W'(GARBAGE_DEPTH));

   // Packets are clipped so the total queued never exceeds the playfield height.
   assign room      = 5'(MAX_PENDING) - pending_total;
   assign store_cnt = min5({1'b0, gb_lines}, room);
   assign push      = gb_valid && !full && !clr && (store_cnt != 5'd0);

   assign cancel_done = (state == ST_CANCEL) && ((rem == 5'd0) || empty);
   assign cancel_step = (state == ST_CANCEL) && !cancel_done;
   assign ins_valid   = (state == ST_INSERT) && !empty;
   assign ins_fire    = ins_valid && ins_ready;

   assign dec_amt   = cancel_step ? min5(rem, {1'b0, head.count}) : (ins_fire ? 5'd1 : 5'd0);
   assign head_left = head.count - dec_amt[3:0];
   assign pop       = (dec_amt != 5'd0) && (head_left == 4'd0);
   assign ins_last  = ins_fire && ((ins_cnt == INS_W'(MAX_INSERT - 1)) ||
                                   (pop && (fifo_cnt == CNT_W'(1)) && !push));

   assign lock_now         = lock_pulse || lock_pend;
   assign lock_now_cleared = lock_pulse ? lock_cleared : lock_pend_cleared;

   assign gb_ready         = !full;
   assign sent_ready       = (state == ST_IDLE);
   assign busy             = !sent_ready;
   assign cancel_valid     = cancel_done;
   assign cancel_remainder = cancel_done ? rem : 5'd0;
   assign ins_hole         = ins_valid ? head.hole : 4'd0;

   garbage_lfsr u_lfsr (
      .clk   (clk),
      .rst   (rst),
      .en    (push),
      .value (rand_val)
   );

   // Entry storage: push and head decrement never target the same slot.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr] <= '{count: store_cnt[3:0], hole: hole_from_rand(rand_val)};
      end
      if (dec_amt != 5'd0) begin
         fifo_mem[rd_ptr].count <= head_left;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         rd_ptr            <= '0;
         wr_ptr            <= '0;
         fifo_cnt          <= '0;
         pending_total     <= 5'd0;
         state             <= ST_IDLE;
         rem               <= 5'd0;
         ins_cnt           <= '0;
         lock_pend         <= 1'b0;
         lock_pend_cleared <= 1'b0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         fifo_cnt      <= fifo_cnt + CNT_W'(push) - CNT_W'(pop);
         pending_total <= pending_total + (push ? store_cnt : 5'd0) - dec_amt;

         if (lock_pulse && (state != ST_IDLE)) begin
            lock_pend         <= 1'b1;
            lock_pend_cleared <= lock_cleared;
         end

         case (state)
            ST_IDLE: begin
               if (sent_valid) begin
                  rem   <= sent_lines;
                  state <= ST_CANCEL;
                  if (lock_pulse) begin
                     lock_pend         <= 1'b1;
                     lock_pend_cleared <= lock_cleared;
                  end
               end else if (lock_now) begin
                  lock_pend <= 1'b0;
                  if (!lock_now_cleared && (pending_total != 5'd0)) begin
                     state   <= ST_INSERT;
                     ins_cnt <= '0;
                  end
               end
            end
            ST_CANCEL: begin
               if (cancel_done) state <= ST_IDLE;
               else             rem   <= rem - dec_amt;
            end
            ST_INSERT: begin
               if (ins_fire) ins_cnt <= ins_cnt + INS_W'(1);
               if (ins_last || empty) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_garbage_receiver.sv
// Self-checking bench for garbage_receiver: packet table plus scoreboarded cancel/insert sequences.
module tb_garbage_receiver;

   logic       clk = 1'b0;
   logic       rst, game_start;
   logic       gb_valid;
   logic [3:0] gb_lines;
   logic       gb_ready;
   logic       sent_valid;
   logic [4:0] sent_lines;
   logic       sent_ready;
   logic       cancel_valid;
   logic [4:0] cancel_remainder;
   logic       lock_pulse, lock_cleared;
   logic       ins_valid;
   logic [3:0] ins_hole;
   logic       ins_ready;
   logic [4:0] pending_total;
   logic       busy;

   always #5 clk = ~clk;

   garbage_receiver dut (
      .clk              (clk),
      .rst              (rst),
      .game_start       (game_start),
      .gb_valid         (gb_valid),
      .gb_lines         (gb_lines),
      .gb_ready         (gb_ready),
      .sent_valid       (sent_valid),
      .sent_lines       (sent_lines),
      .sent_ready       (sent_ready),
      .cancel_valid     (cancel_valid),
      .cancel_remainder (cancel_remainder),
      .lock_pulse       (lock_pulse),
      .lock_cleared     (lock_cleared),
      .ins_valid        (ins_valid),
      .ins_hole         (ins_hole),
      .ins_ready        (ins_ready),
      .pending_total    (pending_total),
      .busy             (busy)
   );

   typedef struct {
      int count;
      int hole;   // -1 until the first row of this entry is seen
   } sb_t;

   typedef struct {
      int lines;
      int exp_pend;
      int exp_ready;
   } vec_t;

   sb_t sb[$];
   int  m_pend;
   int  checks = 0;
   int  errors = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model;
      sb.delete();
      m_pend = 0;
   endtask

   task automatic do_game_start;
      game_start = 1'b1;
      tick();
      game_start = 1'b0;
      clear_model();
   endtask

   task automatic push_pkt(input int lines);
      int st;
      gb_valid = 1'b1;
      gb_lines = 4'(lines);
      st = (sb.size() < 8) ? ((lines < 20 - m_pend) ? lines : 20 - m_pend) : 0;
      if (st > 0) begin
         sb.push_back('{st, -1});
         m_pend += st;
      end
      tick();
      gb_valid = 1'b0;
   endtask

   task automatic take_row(input int hole);
      sb_t e;
      if (sb.size() == 0) begin
         check("row_unexpected", 1, 0);
      end else begin
         e = sb[0];
         check("hole_range", (hole <= 9) ? 1 : 0, 1);
         if (e.hole < 0) e.hole = hole;
         else            check("row_hole", hole, e.hole);
         e.count--;
         m_pend--;
         if (e.count == 0) void'(sb.pop_front());
         else              sb[0] = e;
      end
   endtask

   task automatic run_insert(input bit toggle, output int n);
      bit seen, held, done;
      int hh;
      n = 0; seen = 0; held = 0; done = 0; hh = 0;
      for (int c = 0; c < 200 && !done; c++) begin
         if (ins_valid) begin
            seen = 1;
            ins_ready = toggle ? ((c % 2) == 1) : 1'b1;
            if (ins_ready) begin
               take_row(int'(ins_hole));
               n++;
            end else begin
               held = 1;
               hh   = int'(ins_hole);
            end
            tick();
            if (held) begin
               check("hold_valid", int'(ins_valid), 1);
               check("hold_hole", int'(ins_hole), hh);
               held = 0;
            end
         end else if (seen) begin
            done = 1;
         end else begin
            tick();
         end
      end
      ins_ready = 1'b0;
      if (!done) check("insert_timeout", 0, 1);
      check("hole_after_insert", int'(ins_hole), 0);
   endtask

   task automatic do_cancel(input int lines, input bit with_lock, input int exp_rem);
      int  r, d;
      sb_t e;
      bit  got;
      r = lines;
      while (r > 0 && sb.size() > 0) begin
         e = sb[0];
         d = (r < e.count) ? r : e.count;
         r -= d; e.count -= d; m_pend -= d;
         if (e.count == 0) void'(sb.pop_front());
         else              sb[0] = e;
      end
      sent_valid   = 1'b1;
      sent_lines   = 5'(lines);
      lock_pulse   = with_lock;
      lock_cleared = 1'b0;
      tick();
      sent_valid = 1'b0;
      lock_pulse = 1'b0;
      check("cancel_sent_ready", int'(sent_ready), 0);
      got = 0;
      for (int c = 0; c < 50 && !got; c++) begin
         if (cancel_valid) got = 1;
         else              tick();
      end
      check("cancel_pulse", int'(got), 1);
      check("cancel_rem", int'(cancel_remainder), exp_rem);
      check("cancel_rem_model", int'(cancel_remainder), r);
      tick();
      check("cancel_one_cycle", int'(cancel_valid), 0);
      check("cancel_rem_idle", int'(cancel_remainder), 0);
      check("sent_ready_back", int'(sent_ready), 1);
      check("cancel_pending", int'(pending_total), m_pend);
   endtask

   initial begin
      vec_t tbl[7];
      int   n;
      bit   got;

      rst = 1'b1; game_start = 1'b0; gb_valid = 1'b0; gb_lines = '0;
      sent_valid = 1'b0; sent_lines = '0; lock_pulse = 1'b0; lock_cleared = 1'b0;
      ins_ready = 1'b0;
      clear_model();
      tick(); tick();
      rst = 1'b0;

      check("rst_gb_ready", int'(gb_ready), 1);
      check("rst_sent_ready", int'(sent_ready), 1);
      check("rst_pending", int'(pending_total), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ins_valid", int'(ins_valid), 0);
      check("rst_ins_hole", int'(ins_hole), 0);
      check("rst_cancel_valid", int'(cancel_valid), 0);
      check("rst_cancel_rem", int'(cancel_remainder), 0);

      // Packet accept table, including the clip at 20 and the fully-clipped packet.
      tbl[0] = '{3, 3, 1};
      tbl[1] = '{4, 7, 1};
      tbl[2] = '{0, 7, 1};
      tbl[3] = '{5, 12, 1};
      tbl[4] = '{6, 18, 1};
      tbl[5] = '{5, 20, 1};
      tbl[6] = '{3, 20, 1};
      for (int i = 0; i < 7; i++) begin
         push_pkt(tbl[i].lines);
         check($sformatf("tbl%0d_pending", i), int'(pending_total), tbl[i].exp_pend);
         check($sformatf("tbl%0d_gb_ready", i), int'(gb_ready), tbl[i].exp_ready);
      end

      // One lock drains exactly MAX_INSERT rows across entry boundaries.
      lock_pulse = 1'b1; lock_cleared = 1'b0;
      tick();
      lock_pulse = 1'b0;
      run_insert(1'b0, n);
      check("tbl_insert_rows", n, 8);
      check("tbl_insert_pending", int'(pending_total), 12);

      // FIFO full backpressure.
      do_game_start();
      check("gs_pending", int'(pending_total), 0);
      for (int i = 0; i < 8; i++) push_pkt(1);
      check("full_gb_ready", int'(gb_ready), 0);
      push_pkt(1);
      check("full_pending", int'(pending_total), 8);

      // Queue {3,4}, attack 5.
      do_game_start();
      push_pkt(3); push_pkt(4);
      do_cancel(5, 1'b0, 0);
      check("c1_pending", int'(pending_total), 2);
      lock_pulse = 1'b1; tick(); lock_pulse = 1'b0;
      run_insert(1'b0, n);
      check("c1_head_rows", n, 2);

      // Queue {2}, attack 6 leaves 4.
      do_game_start();
      push_pkt(2);
      do_cancel(6, 1'b0, 4);
      check("c2_pending", int'(pending_total), 0);

      // Queue {10}, insert with toggling ready, then a clearing lock.
      do_game_start();
      push_pkt(10);
      lock_pulse = 1'b1; lock_cleared = 1'b0; tick(); lock_pulse = 1'b0;
      run_insert(1'b1, n);
      check("i_rows", n, 8);
      check("i_pending", int'(pending_total), 2);
      lock_pulse = 1'b1; lock_cleared = 1'b1; tick(); lock_pulse = 1'b0; lock_cleared = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("clr_lock_ins_valid", int'(ins_valid), 0);
         check("clr_lock_busy", int'(busy), 0);
         tick();
      end
      check("clr_lock_pending", int'(pending_total), 2);

      // Simultaneous attack and lock, then game_start mid-insert.
      do_game_start();
      push_pkt(3);
      do_cancel(1, 1'b1, 0);
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
         if (ins_valid) got = 1;
         else           tick();
      end
      check("pend_lock_insert", int'(got), 1);
      check("pend_lock_pending", int'(pending_total), 2);
      ins_ready = 1'b1;
      take_row(int'(ins_hole));
      tick();
      check("mid_ins_valid", int'(ins_valid), 1);
      game_start = 1'b1;
      tick();
      game_start = 1'b0;
      ins_ready  = 1'b0;
      clear_model();
      for (int i = 0; i < 4; i++) begin
         check("gs_ins_valid", int'(ins_valid), 0);
         check("gs_busy", int'(busy), 0);
         check("gs_pend", int'(pending_total), 0);
         tick();
      end

      // rst mid-cancel discards the operation without a pulse.
      push_pkt(5);
      sent_valid = 1'b1; sent_lines = 5'd3; tick(); sent_valid = 1'b0;
      check("rc_busy", int'(busy), 1);
      rst = 1'b1; tick(); rst = 1'b0;
      clear_model();
      for (int i = 0; i < 3; i++) begin
         check("rc_cancel_valid", int'(cancel_valid), 0);
         check("rc_busy_after", int'(busy), 0);
         check("rc_pending", int'(pending_total), 0);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/garbage_receiver.md
GARBAGE_RECEIVER -- requirements
Module: garbage_receiver

Interface
REQ-001 Parameters (name, default, meaning):
- GARBAGE_DEPTH, 8: queue entries.
- MAX_PENDING, 20: cap on total queued garbage rows (PLAYFIELD_ROWS).
- MAX_INSERT, 8: rows inserted per piece lock.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1: single clock; all logic is posedge clk.
- rst, in, 1: reset; synchronous, active-high.
- game_start, in, 1: synchronous clear, same effect as rst.
- gb_valid, in, 1: incoming garbage packet from opponent.
- gb_lines, in, 4: row count of the incoming packet.
- gb_ready, out, 1: packet accepted when gb_valid && gb_ready.
- sent_valid, in, 1: local attack available for cancellation.
- sent_lines, in, 5: local attack row count.
- sent_ready, out, 1: 1 only in IDLE.
- cancel_valid, out, 1: one-cycle pulse at the end of cancellation.
- cancel_remainder, out, 5: attack rows left after cancellation; forwarded to the opponent.
- lock_pulse, in, 1: local piece locked.
- lock_cleared, in, 1: the lock cleared at least one line.
- ins_valid, out, 1: garbage row offered to the playfield.
- ins_hole, out, 4: hole column of the offered row, 0..9.
- ins_ready, in, 1: playfield accepts the row.
- pending_total, out, 5: sum of queued rows.
- busy, out, 1: state != IDLE.

Function
REQ-003 Storage: FIFO of GARBAGE_DEPTH entries {count 4b, hole 4b}. The head entry is the oldest.
REQ-004 gb_ready = FIFO not full; it is independent of FSM state.
REQ-005 Packet accept:
- Stored count = min(gb_lines, MAX_PENDING - pending_total).
- If the stored count is 0, the packet is consumed and nothing is pushed.
REQ-006 Each push takes one hole value from the LFSR, reduced mod 10. All rows of an entry share that hole.
REQ-007 FSM states: IDLE, CANCEL, INSERT.
REQ-008 IDLE, sent_valid=1:
- Latch sent_lines into rem and go to CANCEL.
- If sent_valid and lock_pulse arrive together, cancellation takes priority and the lock is latched in lock_pend.
REQ-009 CANCEL, one step per cycle:
- d = min(rem, head.count).
- rem -= d and head.count -= d.
- Pop the head entry when its count reaches 0.
REQ-010 CANCEL exits when rem==0 or the FIFO is empty:
- Pulse cancel_valid for one cycle with cancel_remainder = rem; the value may be 0.
- Go to IDLE.
REQ-011 Any lock_pulse arriving while state != IDLE sets lock_pend, retaining lock_cleared. Only one pending lock is held; a later lock overwrites it.
REQ-012 IDLE, lock_pulse or lock_pend with lock_cleared=0 and pending_total>0:
- Go to INSERT with ins_cnt=0.
- Clear lock_pend.
- Any other lock in IDLE is consumed with no effect.
REQ-013 INSERT:
- ins_valid=1 and ins_hole=head.hole.
- On ins_ready: head.count -=1 and ins_cnt +=1; pop the head entry at 0.
- ins_valid and ins_hole hold steady while ins_ready=0.
REQ-014 INSERT exits to IDLE after the handshake that makes ins_cnt==MAX_INSERT or empties the FIFO. ins_valid is 0 in the next cycle.
REQ-015 A push and a pop/decrement in the same cycle are both applied.
REQ-016 pending_total is registered and reflects all pushes and decrements of cycle N in cycle N+1.
REQ-017 game_start wins over all simultaneous events.
REQ-018 Outputs are 0 outside their defined cycles: cancel_valid, ins_valid, cancel_remainder, ins_hole.

Reset
REQ-019 On rst or game_start:
- FIFO empty, pending_total=0, state=IDLE, lock_pend=0, rem=0.
- All outputs 0 except gb_ready=1 and sent_ready=1.
REQ-020 The LFSR resets to a fixed nonzero seed, 8'hA5. game_start does not reseed it.
REQ-021 A reset mid-CANCEL or mid-INSERT discards the operation. No cancel_valid is produced.

Structure
REQ-022 DisplayPkg holds GARBAGE_DEPTH, MAX_PENDING, MAX_INSERT, PLAYFIELD_COLS=10, the typedef garbage_entry_t, and the enum gr_state_t.
REQ-023 Sub-module garbage_lfsr: 8-bit maximal Fibonacci LFSR, advancing only on the enable pulse (push).

Verification
REQ-024 Push gb_lines=3, then 4 -> pending_total=7 next cycle; two entries with holes <= 9.
REQ-025 Queue {3,4}, sent_lines=5 -> first entry popped, head.count=2, cancel_valid pulse with remainder 0, pending_total=2.
REQ-026 Queue {2}, sent_lines=6 -> FIFO empty, cancel_remainder=4, sent_ready returns to 1 the cycle after the pulse.
REQ-027 Queue {10}, lock_pulse with lock_cleared=0, ins_ready toggling -> exactly 8 handshakes, all with the same hole; pending_total=2; lock_cleared=1 -> 0 rows inserted.
REQ-028 pending_total=18, gb_lines=5 -> stored count 2 and pending_total=20; then gb_lines=3 -> consumed, nothing pushed.
REQ-029 sent_valid and lock_pulse in the same IDLE cycle with queue {3}, sent_lines=1 -> CANCEL, then INSERT of 2 rows; game_start mid-INSERT -> all cleared, no further ins_valid.
